// File: rtl/gpio_input_conditioner.sv
// ---------------------------------------------------------------------------
// gpio_input_conditioner
//
// Cleans up raw board switch/button levels before they reach the processor's
// GPIO_i port. Each bit passes through a two-flop synchronizer and then a
// counter-based debouncer. The result is a glitch-free byte plus a one-cycle
// strobe that marks any change of that byte.
//
// Optional feature (compile-time macro GPIO_EDGE_CAPTURE_EN):
//   When the macro is defined, sticky per-bit rising/falling edge flags are kept
//   and cleared by clear_i. When it is undefined, rise_o/fall_o are tied low and
//   clear_i is ignored. The port list is the same in both builds.
//
// Parameters
//   WIDTH            number of conditioned bits
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples needed before a
//                    bit updates (>= 1)
//   CNT_W            debounce counter width (2**CNT_W >= DEBOUNCE_CYCLES)
//
// Ports
//   clk       in   system clock, single clock domain
//   reset     in   synchronous, active-high reset
//   pins_i    in   raw asynchronous switch/button levels
//   gpio_o    out  debounced levels, feeds datapath GPIO_i
//   change_o  out  one-cycle pulse when any gpio_o bit changes
//   clear_i   in   clears all sticky edge flags (edge-capture build only)
//   rise_o    out  sticky rising-edge flags (edge-capture build only)
//   fall_o    out  sticky falling-edge flags (edge-capture build only)
// ---------------------------------------------------------------------------
module gpio_input_conditioner #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pins_i,
   output logic [WIDTH-1:0] gpio_o,
   output logic             change_o,
   input  logic             clear_i,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   // Count value at which a pending bit is accepted.
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } deb_state_t;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [CNT_W-1:0] cnt [WIDTH];
   deb_state_t       state [WIDTH];
   logic [WIDTH-1:0] update;
   logic [WIDTH-1:0] gpio_next;

   // A bit's debouncer state follows directly from whether the synchronized
   // level disagrees with the accepted level, so it is derived here rather than
   // held in a separate flop that could drift out of step with gpio_o.
   // A bit updates when it has been pending for the full terminal count.
   always_comb begin
      update = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state[i]  = (sync2[i] != gpio_o[i]) ? PENDING : STABLE;
         update[i] = (state[i] == PENDING) && (cnt[i] == TERM_CNT);
      end
   end

   // Updating bits take the synchronized value, which is the inverse of the
   // current value, so a simple XOR gives the next accepted byte.
   assign gpio_next = gpio_o ^ update;

   // Synchronizer, per-bit debounce counters, accepted levels and change strobe.
   // A bounce back to the accepted level drops the bit to STABLE, which clears
   // its count, so only an unbroken run of differing samples reaches TERM_CNT.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         gpio_o   <= '0;
         change_o <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1    <= pins_i;
         sync2    <= sync1;
         gpio_o   <= gpio_next;
         change_o <= |update;
         for (int i = 0; i < WIDTH; i++) begin
            case (state[i])
               STABLE: begin
                  cnt[i] <= '0;
               end
               PENDING: begin
                  if (update[i]) begin
                     cnt[i] <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + CNT_W'(1);
                  end
               end
               default: begin
                  cnt[i] <= '0;
               end
            endcase
         end
      end
   end

`ifdef GPIO_EDGE_CAPTURE_EN
   // Sticky edge flags. The direction of an update is the new value, which is
   // the synchronized level of that bit. A new edge in the same cycle as
   // clear_i is OR-ed in after the clear, so the set wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_o <= '0;
         fall_o <= '0;
      end else begin
         rise_o <= (clear_i ? '0 : rise_o) | (update & sync2);
         fall_o <= (clear_i ? '0 : fall_o) | (update & ~sync2);
      end
   end
`else
   logic unused_clear;

   // Edge capture is compiled out; the flags stay low and clear_i is a no-op.
   assign rise_o       = '0;
   assign fall_o       = '0;
   assign unused_clear = clear_i;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_gpio_input_conditioner
//
// Bench for gpio_input_conditioner with DEBOUNCE_CYCLES = 4, WIDTH = 8.
// A table of stimulus segments (inputs held for some cycles, hand-derived
// outputs expected after the last cycle) drives the design. Every cycle an
// independent reference model predicts the outputs; the prediction is queued
// when the stimulus is driven and popped when the outputs are sampled.
// The reference model treats a bit as accepted once the last DEBOUNCE_CYCLES
// synchronized samples all differ from the current output.
// ---------------------------------------------------------------------------
module tb_gpio_input_conditioner;

   localparam int WIDTH = 8;
   localparam int DC    = 4;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] pins_i;
   logic [WIDTH-1:0] gpio_o;
   logic             change_o;
   logic             clear_i;
   logic [WIDTH-1:0] rise_o;
   logic [WIDTH-1:0] fall_o;

   always #5 clk = ~clk;

   gpio_input_conditioner #(
      .WIDTH(WIDTH),
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pins_i(pins_i),
      .gpio_o(gpio_o),
      .change_o(change_o),
      .clear_i(clear_i),
      .rise_o(rise_o),
      .fall_o(fall_o)
   );

   typedef struct {
      logic [7:0] gpio;
      logic       change;
      logic [7:0] rise;
      logic [7:0] fall;
   } exp_t;

   typedef struct {
      logic       rst;
      logic       clr;
      logic [7:0] pins;
      int         hold;
      logic [7:0] gpio;
      logic       change;
      logic       chk_edge;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] m_s1, m_s2, m_gpio, m_rise, m_fall;
   logic       m_change;
   logic [7:0] m_win [DC];

   logic       saw_change;

   function automatic void modelStep(input logic rst, input logic clr, input logic [7:0] pins);
      logic [7:0] upd;
      logic [7:0] nxt;
      if (rst) begin
         m_s1     = '0;
         m_s2     = '0;
         m_gpio   = '0;
         m_change = 1'b0;
         m_rise   = '0;
         m_fall   = '0;
         for (int k = 0; k < DC; k++) m_win[k] = '0;
      end else begin
         for (int k = DC - 1; k > 0; k--) m_win[k] = m_win[k-1];
         m_win[0] = m_s2;
         upd = 8'hFF;
         for (int k = 0; k < DC; k++) upd = upd & (m_win[k] ^ m_gpio);
         nxt      = m_gpio ^ upd;
         m_change = |upd;
         m_rise   = (clr ? 8'h00 : m_rise) | (upd & nxt);
         m_fall   = (clr ? 8'h00 : m_fall) | (upd & ~nxt);
         m_gpio   = nxt;
         m_s2     = m_s1;
         m_s1     = pins;
      end
   endfunction

   task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = exp_q.pop_front();
         checkVal("sb gpio_o", gpio_o, e.gpio);
         checkVal("sb change_o", {7'b0, change_o}, {7'b0, e.change});
         checkVal("sb rise_o", rise_o, e.rise);
         checkVal("sb fall_o", fall_o, e.fall);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic clr, input logic [7:0] pins);
      exp_t e;
      reset   = rst;
      clear_i = clr;
      pins_i  = pins;
      modelStep(rst, clr, pins);
      e.gpio   = m_gpio;
      e.change = m_change;
`ifdef GPIO_EDGE_CAPTURE_EN
      e.rise   = m_rise;
      e.fall   = m_fall;
`else
      e.rise   = 8'h00;
      e.fall   = 8'h00;
`endif
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (change_o === 1'b1) saw_change = 1'b1;
      checkOutput();
   endtask

   task automatic runVecs(input int first, input int last);
      vec_t v;
      for (int i = first; i <= last; i++) begin
         v = vecs[i];
         repeat (v.hold) applyStimulus(v.rst, v.clr, v.pins);
         checkVal($sformatf("vec%0d gpio_o", i), gpio_o, v.gpio);
         checkVal($sformatf("vec%0d change_o", i), {7'b0, change_o}, {7'b0, v.change});
         if (v.chk_edge) begin
`ifdef GPIO_EDGE_CAPTURE_EN
            checkVal($sformatf("vec%0d rise_o", i), rise_o, v.rise);
            checkVal($sformatf("vec%0d fall_o", i), fall_o, v.fall);
`else
            checkVal($sformatf("vec%0d rise_o", i), rise_o, 8'h00);
            checkVal($sformatf("vec%0d fall_o", i), fall_o, 8'h00);
`endif
         end
      end
   endtask

   initial begin
      // rst clr pins hold | gpio change chk rise fall
      // Reset with pins high, then first debounce after release
      vecs.push_back('{1'b1, 1'b0, 8'hFF, 3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 0
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 1
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00}); // 2
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 3, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00}); // 3
      // Back to zero, then single-bit change 00 -> 01
      vecs.push_back('{1'b0, 1'b0, 8'h00, 5, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00}); // 4
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00}); // 5
      vecs.push_back('{1'b0, 1'b0, 8'h00, 4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 6
      vecs.push_back('{1'b0, 1'b0, 8'h01, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 7
      vecs.push_back('{1'b0, 1'b0, 8'h01, 1, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00}); // 8
      vecs.push_back('{1'b0, 1'b0, 8'h01, 1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00}); // 9
      // Multi-bit simultaneous update 00 -> A5
      vecs.push_back('{1'b0, 1'b0, 8'h00, 5, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00}); // 10
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00}); // 11
      vecs.push_back('{1'b0, 1'b0, 8'h00, 2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 12
      vecs.push_back('{1'b0, 1'b0, 8'hA5, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 13
      vecs.push_back('{1'b0, 1'b0, 8'hA5, 1, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00}); // 14
      vecs.push_back('{1'b0, 1'b0, 8'hA5, 2, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00}); // 15
      // Reset at count 2 mid-debounce, full restart afterwards
      vecs.push_back('{1'b0, 1'b0, 8'h00, 5, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00}); // 16
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00}); // 17
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 4, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 18
      vecs.push_back('{1'b1, 1'b0, 8'hFF, 1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 19
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 20
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00}); // 21
      vecs.push_back('{1'b0, 1'b0, 8'hFF, 1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00}); // 22
      // Edge flags: clear, falls, bit 0 rise/fall, clear vs. new rise on bit 1
      vecs.push_back('{1'b0, 1'b1, 8'hFF, 1, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h00}); // 23
      vecs.push_back('{1'b0, 1'b0, 8'h00, 5, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00}); // 24
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b1, 8'h00, 8'hFF}); // 25
      vecs.push_back('{1'b0, 1'b1, 8'h00, 1, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00}); // 26
      vecs.push_back('{1'b0, 1'b0, 8'h01, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 27
      vecs.push_back('{1'b0, 1'b0, 8'h01, 1, 8'h01, 1'b1, 1'b1, 8'h01, 8'h00}); // 28
      vecs.push_back('{1'b0, 1'b0, 8'h00, 5, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00}); // 29
      vecs.push_back('{1'b0, 1'b0, 8'h00, 1, 8'h00, 1'b1, 1'b1, 8'h01, 8'h01}); // 30
      vecs.push_back('{1'b0, 1'b0, 8'h02, 5, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}); // 31
      vecs.push_back('{1'b0, 1'b1, 8'h02, 1, 8'h02, 1'b1, 1'b1, 8'h02, 8'h00}); // 32
      vecs.push_back('{1'b0, 1'b0, 8'h02, 2, 8'h02, 1'b0, 1'b1, 8'h02, 8'h00}); // 33

      reset      = 1'b1;
      clear_i    = 1'b0;
      pins_i     = 8'hFF;
      saw_change = 1'b0;

      $display("[TB] reset and single-bit debounce");
      runVecs(0, 9);

      // Bit 3 bounces every two cycles for twenty cycles, then settles at 0;
      // no run is long enough to be accepted.
      $display("[TB] bounce on bit 3");
      saw_change = 1'b0;
      for (int k = 0; k < 10; k++) begin
         repeat (2) applyStimulus(1'b0, 1'b0, (k % 2 == 0) ? 8'h09 : 8'h01);
      end
      repeat (8) applyStimulus(1'b0, 1'b0, 8'h01);
      checkVal("bounce gpio_o", gpio_o, 8'h01);
      checkVal("bounce change_o seen", {7'b0, saw_change}, 8'h00);

      $display("[TB] multi-bit, mid-debounce reset, edge flags");
      runVecs(10, 33);

      checkVal("scoreboard drained", 8'(exp_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected end of test");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $finish;
   end

endmodule
